// File: rtl/hsadc_capture_controller_if.sv
// -----------------------------------------------------------------------------
// hsadc_capture_controller_if
// AXI-Stream style handshake bundle used on both sides of the capture
// controller: a W-bit sample stream into the block and an 8-bit byte stream
// out to the host.
//   tdata  : payload
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : final beat of a packet (only the byte stream drives it)
// -----------------------------------------------------------------------------
interface hsadc_capture_controller_if #(
   parameter int W = 8
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/hsadc_capture_controller.sv
// -----------------------------------------------------------------------------
// hsadc_capture_controller
// Sequences ADC acquisitions onto the host byte stream. On arm it waits for a
// trigger on channel A, then emits one packet: HEADER_BYTE, count[15:8],
// count[7:0], then ch A / ch B bytes for each captured sample. While idle or
// waiting for a trigger the sample stream is drained so upstream never stalls.
// Ports:
//   stream_clk    : clock, rising edge
//   reset         : asynchronous, active-low
//   arm, abort    : start request / cancel a pending trigger
//   sample_count  : samples per capture (latched on accepted arm)
//   trigger_mode  : 0/3 immediate, 1 rising ch A, 2 falling ch A
//   trigger_level : ch A threshold
//   s_axis        : 16-bit sample stream in (ch A [7:0], ch B [15:8])
//   m_axis        : 8-bit host byte stream out, tlast on final byte
//   busy          : high whenever not idle
//   done          : one-cycle pulse after the final byte is accepted
// -----------------------------------------------------------------------------
module hsadc_capture_controller #(
   parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
   input  logic                              stream_clk,
   input  logic                              reset,
   input  logic                              arm,
   input  logic                              abort,
   input  logic [15:0]                       sample_count,
   input  logic [1:0]                        trigger_mode,
   input  logic [7:0]                        trigger_level,
   hsadc_capture_controller_if.slave         s_axis,
   hsadc_capture_controller_if.master        m_axis,
   output logic                              busy,
   output logic                              done
);

   typedef enum logic [2:0] {
      IDLE, WAIT_TRIG, HDR0, HDR1, HDR2, BYTE_A, BYTE_B, FETCH
   } state_t;

   state_t      state, state_nxt;
   logic        ready_en;
   logic [15:0] remaining;
   logic [15:0] cnt;
   logic [1:0]  mode;
   logic [7:0]  level;
   logic [7:0]  prev_a;
   logic        prev_valid;
   logic [15:0] sample_reg;
   logic        s_ready, s_take;
   logic        m_valid, m_fire, m_last;
   logic [7:0]  m_data;
   logic        arm_ok, trig;

   // Channel A bytes are treated as unsigned codes for threshold crossing.
   function automatic logic trig_hit(input logic [1:0] md, input logic pv,
                                     input logic [7:0] pa, input logic [7:0] ca,
                                     input logic [7:0] lv);
      case (md)
         2'd1:    trig_hit = pv && (pa < lv) && (ca >= lv);
         2'd2:    trig_hit = pv && (pa > lv) && (ca <= lv);
         default: trig_hit = 1'b1;
      endcase
   endfunction

   assign arm_ok = arm && (sample_count != 16'd0);
   assign trig   = trig_hit(mode, prev_valid, prev_a, s_axis.tdata[7:0], level);
   assign s_take = s_axis.tvalid && s_ready;
   assign m_fire = m_valid && m_axis.tready;

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      m_data    = 8'h00;
      m_last    = 1'b0;
      case (state)
         IDLE: begin
            // ready_en keeps s_tready low until the first clock after reset.
            s_ready = ready_en;
            if (arm_ok) state_nxt = WAIT_TRIG;
         end
         WAIT_TRIG: begin
            s_ready = 1'b1;
            if (abort)
               state_nxt = IDLE;
            else if (s_axis.tvalid && trig)
               state_nxt = HDR0;
         end
         HDR0: begin
            m_valid = 1'b1;
            m_data  = HEADER_BYTE;
            if (m_fire) state_nxt = HDR1;
         end
         HDR1: begin
            m_valid = 1'b1;
            m_data  = cnt[15:8];
            if (m_fire) state_nxt = HDR2;
         end
         HDR2: begin
            m_valid = 1'b1;
            m_data  = cnt[7:0];
            if (m_fire) state_nxt = BYTE_A;
         end
         BYTE_A: begin
            m_valid = 1'b1;
            m_data  = sample_reg[7:0];
            if (m_fire) state_nxt = BYTE_B;
         end
         BYTE_B: begin
            m_valid = 1'b1;
            m_data  = sample_reg[15:8];
            m_last  = (remaining == 16'd1);
            if (m_fire) state_nxt = m_last ? IDLE : FETCH;
         end
         FETCH: begin
            s_ready = 1'b1;
            if (s_axis.tvalid) state_nxt = BYTE_A;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = m_valid;
   assign m_axis.tdata  = m_data;
   assign m_axis.tlast  = m_last;
   assign busy          = (state != IDLE);

   always_ff @(posedge stream_clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ready_en   <= 1'b0;
         done       <= 1'b0;
         remaining  <= 16'd0;
         prev_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
         done     <= (state == BYTE_B) && m_fire && (remaining == 16'd1);
         if ((state == IDLE) && arm_ok) begin
            remaining  <= sample_count;
            prev_valid <= 1'b0;
         end else begin
            if ((state == BYTE_B) && m_fire) remaining <= remaining - 16'd1;
            if ((state == WAIT_TRIG) && s_take) prev_valid <= 1'b1;
         end
      end
   end

   // Datapath registers carry no reset; they are always written before use.
   always_ff @(posedge stream_clk) begin
      if ((state == IDLE) && arm_ok) begin
         cnt   <= sample_count;
         mode  <= trigger_mode;
         level <= trigger_level;
      end
      if ((state == WAIT_TRIG) && s_take) prev_a <= s_axis.tdata[7:0];
      if (((state == WAIT_TRIG) || (state == FETCH)) && s_take)
         sample_reg <= s_axis.tdata;
   end

endmodule
